// File: rtl/instr_fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, fetches over a req/ready handshake,
// redirects on jr/jump/branch. Optional perf counters with FETCH_PERF_CNT_EN.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        alu_zero,
   input  logic [31:0] branch_offset,
   input  logic        jump_signal,
   input  logic        jr_signal,
   input  logic [31:0] jr_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
`endif
);

   localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

   typedef enum logic [0:0] {StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_q, buf_d;

   logic        branch_taken;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_inc;

   always_comb begin
      branch_taken = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
      redirect     = valid_q & ~stall & (jr_signal | jump_signal | branch_taken);
      pc_inc       = pc_q + 32'd4;
      // jr beats jump beats branch when several are asserted together
      if (jr_signal) begin
         target = jr_target;
      end else if (jump_signal) begin
         target = {pc4_q[31:28], instr_q[25:0], 2'b00};
      end else begin
         target = pc4_q + (branch_offset << 2);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      buf_d   = buf_q;

      if (redirect) begin
         // Any in-flight response and any buffered word belong to the wrong path
         pc_d    = target & 32'hFFFF_FFFC;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = StFetch;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ready) begin
                  if (!stall) begin
                     instr_d = imem_rdata;
                     pc4_d   = pc_inc;
                     valid_d = 1'b1;
                     pc_d    = pc_inc;
                  end else begin
                     buf_d   = imem_rdata;
                     state_d = StHold;
                  end
               end else if (!stall) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
            end
            StHold: begin
               if (!stall) begin
                  instr_d = buf_q;
                  pc4_d   = pc_inc;
                  valid_d = 1'b1;
                  pc_d    = pc_inc;
                  state_d = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         pc_q    <= ResetPcAligned;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         buf_q   <= buf_d;
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];

`ifdef FETCH_PERF_CNT_EN
   logic        fetch_load;
   logic [31:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;

   // A valid IF/ID load happens on a non-redirected, non-stalled cycle with a word available
   assign fetch_load = ~redirect & ~stall & ((state_q == StHold) | imem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (fetch_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (redirect)   flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model checked every cycle.
module tb_instr_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        branch_eq;
   logic        branch_ne;
   logic        alu_zero;
   logic [31:0] branch_offset;
   logic        jump_signal;
   logic        jr_signal;
   logic [31:0] jr_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] flush_count;
`endif

   instr_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .branch_eq     (branch_eq),
      .branch_ne     (branch_ne),
      .alu_zero      (alu_zero),
      .branch_offset (branch_offset),
      .jump_signal   (jump_signal),
      .jr_signal     (jr_signal),
      .jr_target     (jr_target),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .opcode        (opcode),
      .funct         (funct)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count),
      .flush_count   (flush_count)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: mem[i]=i in directed mode, hashed contents in random mode
   logic hash_mode = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
      if (h) return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      return {2'b00, a[31:2]};
   endfunction

   always_comb imem_rdata = mem_word(imem_addr, hash_mode);

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: current (m_) and next (n_) architectural view
   logic [31:0] m_pc, m_instr, m_pc4, m_buf, n_pc, n_instr, n_pc4, n_buf;
   logic        m_valid, m_hold, n_valid, n_hold;
   logic [31:0] m_fetches, m_flushes, n_fetches, n_flushes;
   logic        chk_en = 1'b0;

   task automatic model_reset();
      m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
      m_hold = 1'b0; m_buf = 32'd0; m_fetches = 32'd0; m_flushes = 32'd0;
   endtask

   task automatic model_next();
      logic        taken;
      logic [31:0] tgt;
      n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
      n_hold = m_hold; n_buf = m_buf; n_fetches = m_fetches; n_flushes = m_flushes;
      taken = m_valid && !stall &&
              (jr_signal || jump_signal || (branch_eq && alu_zero) || (branch_ne && !alu_zero));
      if (taken) begin
         if (jr_signal)        tgt = jr_target;
         else if (jump_signal) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
         else                  tgt = m_pc4 + branch_offset * 32'd4;
         n_pc = tgt & 32'hFFFF_FFFC;
         n_instr = NOP; n_valid = 1'b0; n_hold = 1'b0;
         n_flushes = m_flushes + 32'd1;
      end else if (m_hold) begin
         if (!stall) begin
            n_instr = m_buf; n_pc4 = m_pc + 32'd4; n_pc = m_pc + 32'd4;
            n_valid = 1'b1; n_hold = 1'b0; n_fetches = m_fetches + 32'd1;
         end
      end else if (imem_ready) begin
         if (!stall) begin
            n_instr = mem_word(m_pc, hash_mode); n_pc4 = m_pc + 32'd4; n_pc = m_pc + 32'd4;
            n_valid = 1'b1; n_fetches = m_fetches + 32'd1;
         end else begin
            n_hold = 1'b1; n_buf = mem_word(m_pc, hash_mode);
         end
      end else if (!stall) begin
         n_instr = NOP; n_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, !m_hold});
         check("imem_addr", imem_addr, m_pc);
         check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
         check("if_id_instr", if_id_instr, m_instr);
         if (m_valid) check("if_id_pc4", if_id_pc4, m_pc4);
         check("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
         check("funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
`ifdef FETCH_PERF_CNT_EN
         check("fetch_count", fetch_count, m_fetches);
         check("flush_count", flush_count, m_flushes);
`endif
      end
   end

   // One clock: drive inputs, step model, let the edge pass; returns at negedge+1
   task automatic cyc_full(input logic st, input logic rdy, input logic beq, input logic bne,
                           input logic z, input logic [31:0] off, input logic j,
                           input logic jr, input logic [31:0] jt);
      stall = st; imem_ready = rdy; branch_eq = beq; branch_ne = bne; alu_zero = z;
      branch_offset = off; jump_signal = j; jr_signal = jr; jr_target = jt;
      model_next();
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
      m_hold = n_hold; m_buf = n_buf; m_fetches = n_fetches; m_flushes = n_flushes;
      @(negedge clk);
      #1;
   endtask

   task automatic cyc(input logic st, input logic rdy);
      cyc_full(st, rdy, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   // Asynchronous reset asserted mid low phase, checked before any clock edge
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd1);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, NOP);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_flush_count", flush_count, 32'd0);
`endif
      model_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; imem_ready = 1'b1; branch_eq = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0;
      branch_offset = 32'd0; jump_signal = 1'b0; jr_signal = 1'b0; jr_target = 32'd0;
      model_reset();
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      check("reset_req", {31'd0, imem_req}, 32'd1);
      check("reset_addr", imem_addr, 32'd0);
      check("reset_pc4", if_id_pc4, 32'd0);
      rst_n = 1'b1;

      // Streaming fetch with ready held high
      cyc(1'b0, 1'b1);
      check("first_valid", {31'd0, if_id_valid}, 32'd1);
      check("first_instr", if_id_instr, 32'd0);
      check("first_pc4", if_id_pc4, 32'd4);
      check("first_next_addr", imem_addr, 32'd4);
      cyc(1'b0, 1'b1);
      check("second_instr", if_id_instr, 32'd1);
      check("second_addr", imem_addr, 32'd8);

      // Memory wait states at address 8
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0);
         check("wait_addr", imem_addr, 32'd8);
         check("wait_valid", {31'd0, if_id_valid}, 32'd0);
      end
      cyc(1'b0, 1'b1);
      check("after_wait_instr", if_id_instr, 32'd2);
      check("after_wait_pc4", if_id_pc4, 32'd12);

      // Stall while the response arrives: word parked, IF/ID frozen
      cyc(1'b1, 1'b1);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_instr", if_id_instr, 32'd2);
      cyc(1'b1, 1'b1);
      check("hold2_req", {31'd0, imem_req}, 32'd0);
      cyc(1'b0, 1'b0);
      check("unhold_instr", if_id_instr, 32'd3);
      check("unhold_pc4", if_id_pc4, 32'd16);
      check("unhold_addr", imem_addr, 32'd16);

      // BEQ at 0x10, taken, offset 3 -> 0x14 + 12 = 0x20
      cyc(1'b0, 1'b1);
      check("beq_src_instr", if_id_instr, 32'd4);
      cyc_full(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 32'd0);
      check("beq_addr", imem_addr, 32'h20);
      check("beq_bubble", {31'd0, if_id_valid}, 32'd0);
      cyc(1'b0, 1'b1);
      check("beq_target_instr", if_id_instr, 32'd8);

      // BNE with equal operands does not redirect
      cyc_full(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 32'd0);
      check("bne_valid", {31'd0, if_id_valid}, 32'd1);
      check("bne_addr", imem_addr, 32'h28);

      // JR to 0x100, then J imm26=0x40 from there lands back on 0x100
      cyc_full(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h100);
      check("jr_addr", imem_addr, 32'h100);
      cyc(1'b0, 1'b1);
      check("j_src_instr", if_id_instr, 32'h40);
      cyc_full(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      check("j_addr", imem_addr, 32'h100);
      cyc(1'b0, 1'b1);
      cyc_full(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b1, 1'b1, 32'h2D);
      check("jr_wins_addr", imem_addr, 32'h2C);

      // Reset while parked in HOLD
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      check("pre_reset_hold", {31'd0, imem_req}, 32'd0);
      do_reset();

      // Randomized traffic
      hash_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cyc_full($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1, {{16{r[15]}}, r[15:0]},
                     $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom);
         end
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
